pkt_rr_arb: RTL and testbench
=============================

PKT_RR_ARB -- requirements
Module: pkt_rr_arb

Interface
REQ-001 Parameter NPORT, default 4: number of input packet ports, range 2..8.
REQ-002 Parameter TIMEOUT, default 16: consecutive idle cycles within a granted packet before the grant is revoked, range 2..255.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 in_data  input  NPORT*8  per-port byte; port i occupies bits [8i+7:8i].
REQ-006 in_sop  input  NPORT  per-port start-of-packet flag.
REQ-007 in_eop  input  NPORT  per-port end-of-packet flag.
REQ-008 in_vld  input  NPORT  per-port beat valid.
REQ-009 in_rdy  output  NPORT  per-port beat accept; a beat transfers when in_vld[i] & in_rdy[i].
REQ-010 out_data  output  8  merged output byte, registered.
REQ-011 out_sop / out_eop / out_vld  output  1 each  merged output flags, registered.
REQ-012 gnt  output  NPORT  one-hot current grant, all-zero when idle, registered.
REQ-013 err  output  1  one-cycle protocol/timeout error pulse, registered.

Function
REQ-014 The FSM SHALL have two states: IDLE (no grant) and XFER (grant held by one port).
REQ-015 In IDLE, the eligible ports SHALL be those with in_vld & in_sop; if any exist, the winner SHALL be the first eligible port at or after pointer ptr, searching upward modulo NPORT; gnt SHALL load the winner one-hot, and the FSM SHALL enter XFER on the next edge.
REQ-016 In IDLE, in_rdy SHALL be 0 for ports presenting in_sop.
REQ-017 In XFER, in_rdy[g] SHALL be 1 combinationally for the granted port g.
REQ-018 Grant SHALL be packet-granular: there is no switch between the sop and eop of a packet.
REQ-019 Each accepted beat of port g SHALL appear on out_data/out_sop/out_eop with out_vld=1 exactly one cycle after acceptance; otherwise out_vld=0, and out_sop/out_eop SHALL be 0.
REQ-020 Start latency from sop first presented (with no competition) to out_vld SHALL be 2 cycles (grant cycle, then accept cycle).
REQ-021 On acceptance of a beat with in_eop=1, the FSM SHALL return to IDLE, gnt SHALL clear, and ptr SHALL become (g+1) mod NPORT.
REQ-022 A single-beat packet (sop=eop=1) SHALL be forwarded as such and SHALL release the grant as in REQ-021.
REQ-023 There SHALL be one idle cycle between back-to-back packets on the output.
REQ-024 A non-granted port presenting in_vld & ~in_sop SHALL be treated as a stray beat:
- in_rdy=1 for that port, so the beat is dropped and never forwarded
- err pulses on the following cycle.
REQ-025 A granted-port beat with in_sop=1 other than the first beat of the packet SHALL be forwarded unchanged, with err pulsing one cycle later; the grant continues until eop.
REQ-026 In XFER, the idle counter SHALL:
- increment each cycle with no accepted beat
- clear on each accepted beat and on entry to XFER.
REQ-027 When the idle counter reaches TIMEOUT, the block SHALL:
- return to IDLE
- clear gnt
- set ptr=(g+1) mod NPORT
- pulse err
It SHALL emit no synthetic eop; later beats from g without sop are handled per REQ-024.
REQ-028 Multiple err causes in one cycle SHALL produce a single err pulse.

Reset
REQ-029 While rst_n=0 at posedge clk, the block SHALL clear:
- state=IDLE, ptr=0, gnt=0, idle counter=0
- out_vld=out_sop=out_eop=0, out_data=8'h00, err=0.
REQ-030 While rst_n=0, in_rdy SHALL be all-zero.
REQ-031 Reset asserted mid-packet SHALL abandon the packet with no eop emitted; the next packet SHALL start cleanly after rst_n rises.

Verification
REQ-032 Reset release, port0 sends 3-beat packet 0xA1,0xA2,0xA3 -> out_vld on cycles t+2..t+4, sop with 0xA1, eop with 0xA3, gnt=4'b0001 then 4'b0000.
REQ-033 Ports 0..3 all request simultaneously with 2-beat packets, ptr=0 -> output order 0,1,2,3, each followed by one idle cycle; ptr ends at 0.
REQ-034 Port2 stalls in_vld low for 16 cycles after its sop beat -> err pulse, gnt=0, ptr=3; later port2 beats without sop are dropped with err.
REQ-035 Port1 presents vld without sop while port0 is granted -> port1 beat dropped, err pulses once, port0 packet output intact.
REQ-036 rst_n driven low for 1 cycle in the middle of a port3 packet -> all outputs zero next cycle; a new port0 packet then forwards with 2-cycle latency.
REQ-037 Port1 sends sop&eop single-beat packet 0x5C while port2 waits -> 0x5C output with sop=eop=1, then port2 granted after one idle cycle.

Source files
------------

// File: rtl/pkt_rr_arb.sv
// pkt_rr_arb: round-robin packet arbiter merging NPORT byte streams onto one
// registered output. A grant is held for a whole packet (sop..eop). Stray
// beats from non-granted ports are swallowed and flagged. A granted packet
// that goes quiet for TIMEOUT cycles loses its grant.
module pkt_rr_arb #(
  parameter int unsigned NPORT   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NPORT*8-1:0] in_data,
  input  logic [NPORT-1:0]   in_sop,
  input  logic [NPORT-1:0]   in_eop,
  input  logic [NPORT-1:0]   in_vld,
  output logic [NPORT-1:0]   in_rdy,
  output logic [7:0]         out_data,
  output logic               out_sop,
  output logic               out_eop,
  output logic               out_vld,
  output logic [NPORT-1:0]   gnt,
  output logic               err
);

  localparam int unsigned      PW         = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [7:0]       TimeoutCnt = 8'(TIMEOUT);
  localparam logic [NPORT-1:0] OneLsb     = {{(NPORT-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NPORT-1:0] gnt_q, gnt_d;
  logic [7:0]       idle_cnt_q, idle_cnt_d;
  logic             first_q, first_d;    // next accepted beat is the packet's first
  logic [7:0]       out_data_q, out_data_d;
  logic             out_sop_q, out_sop_d;
  logic             out_eop_q, out_eop_d;
  logic             out_vld_q, out_vld_d;
  logic             err_q, err_d;

  logic [NPORT-1:0] rdy;
  logic [NPORT-1:0] elig;
  logic [NPORT-1:0] stray;
  logic [7:0]       port_data [NPORT];
  logic [PW-1:0]    cand      [NPORT];
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    ptr_next;
  logic [PW-1:0]    win_idx;
  logic             win_found;
  logic [NPORT-1:0] win_oh;
  logic             g_vld, g_sop, g_eop;
  logic [7:0]       g_data;
  logic [7:0]       idle_inc;

  // Split the flat data bus into per-port bytes.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      port_data[i] = in_data[i*8 +: 8];
    end
  end

  // Index of the currently granted port (gnt_q is one-hot or zero).
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (gnt_q[i]) begin
        gnt_idx = PW'(i);
      end
    end
  end

  assign g_vld    = in_vld[gnt_idx];
  assign g_sop    = in_sop[gnt_idx];
  assign g_eop    = in_eop[gnt_idx];
  assign g_data   = port_data[gnt_idx];
  assign ptr_next = (gnt_idx == PW'(NPORT - 1)) ? '0 : gnt_idx + PW'(1);
  assign idle_inc = idle_cnt_q + 8'd1;

  // Only a fresh packet head can compete for the grant.
  assign elig  = in_vld & in_sop;
  // Non-sop beats from any port not holding the grant are dropped.
  assign stray = in_vld & ~in_sop & ~gnt_q;

  // Round-robin pick: first eligible port at or after ptr_q, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NPORT; k++) begin
      cand[k] = PW'((int'(ptr_q) + k) % NPORT);
      if (!win_found && elig[cand[k]]) begin
        win_found = 1'b1;
        win_idx   = cand[k];
      end
    end
    win_oh = OneLsb << win_idx;
  end

  // Next-state, grant bookkeeping and registered-output staging.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    idle_cnt_d = idle_cnt_q;
    first_d    = first_q;
    out_data_d = 8'h00;
    out_sop_d  = 1'b0;
    out_eop_d  = 1'b0;
    out_vld_d  = 1'b0;
    err_d      = |stray;
    rdy        = stray;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          gnt_d      = win_oh;
          state_d    = StXfer;
          idle_cnt_d = 8'd0;
          first_d    = 1'b1;
        end
      end
      StXfer: begin
        rdy = rdy | gnt_q;
        if (g_vld) begin
          out_vld_d  = 1'b1;
          out_data_d = g_data;
          out_sop_d  = g_sop;
          out_eop_d  = g_eop;
          idle_cnt_d = 8'd0;
          first_d    = 1'b0;
          // A sop inside a packet is forwarded but flagged.
          if (g_sop && !first_q) begin
            err_d = 1'b1;
          end
          if (g_eop) begin
            state_d = StIdle;
            gnt_d   = '0;
            ptr_d   = ptr_next;
          end
        end else begin
          idle_cnt_d = idle_inc;
          // Stalled packet: revoke without inventing an eop.
          if (idle_inc == TimeoutCnt) begin
            state_d    = StIdle;
            gnt_d      = '0;
            ptr_d      = ptr_next;
            idle_cnt_d = 8'd0;
            err_d      = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  // Ready is suppressed entirely while reset is asserted.
  assign in_rdy = rst_n ? rdy : '0;

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      gnt_q      <= '0;
      idle_cnt_q <= 8'd0;
      first_q    <= 1'b0;
      out_data_q <= 8'h00;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      idle_cnt_q <= idle_cnt_d;
      first_q    <= first_d;
      out_data_q <= out_data_d;
      out_sop_q  <= out_sop_d;
      out_eop_q  <= out_eop_d;
      out_vld_q  <= out_vld_d;
      err_q      <= err_d;
    end
  end

  assign out_data = out_data_q;
  assign out_sop  = out_sop_q;
  assign out_eop  = out_eop_q;
  assign out_vld  = out_vld_q;
  assign gnt      = gnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_pkt_rr_arb.sv
// tb_pkt_rr_arb: directed scenarios plus randomized per-port packet sources,
// all compared cycle by cycle against a behavioural arbiter model.
module tb_pkt_rr_arb;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*8-1:0] data;
  logic [N-1:0]   sop, eop, vld;
  logic [N-1:0]   in_rdy;
  logic [7:0]     out_data;
  logic           out_sop, out_eop, out_vld, err;
  logic [N-1:0]   gnt;

  pkt_rr_arb #(
    .NPORT  (N),
    .TIMEOUT(TO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data (data),
    .in_sop  (sop),
    .in_eop  (eop),
    .in_vld  (vld),
    .in_rdy  (in_rdy),
    .out_data(out_data),
    .out_sop (out_sop),
    .out_eop (out_eop),
    .out_vld (out_vld),
    .gnt     (gnt),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural model: owner is the granted port (-1 when none).
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_idle  = 0;
  bit         m_first = 0;
  logic       e_vld, e_sop, e_eop, e_err;
  logic [7:0] e_data;
  logic [N-1:0] e_gnt;

  function automatic logic [N-1:0] model_rdy();
    logic [N-1:0] r;
    r = '0;
    if (rst_n) begin
      for (int p = 0; p < N; p++) r[p] = (p == m_owner) || (vld[p] && !sop[p]);
    end
    return r;
  endfunction

  task automatic model_edge();
    e_vld = 0; e_sop = 0; e_eop = 0; e_err = 0; e_data = 8'h00;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_idle = 0; m_first = 0;
    end else begin
      for (int p = 0; p < N; p++) if (p != m_owner && vld[p] && !sop[p]) e_err = 1;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          int p;
          p = (m_ptr + k) % N;
          if (m_owner < 0 && vld[p] && sop[p]) begin
            m_owner = p; m_idle = 0; m_first = 1;
          end
        end
      end else if (vld[m_owner]) begin
        e_vld  = 1;
        e_sop  = sop[m_owner];
        e_eop  = eop[m_owner];
        e_data = data[8*m_owner +: 8];
        if (sop[m_owner] && !m_first) e_err = 1;
        m_first = 0;
        m_idle  = 0;
        if (eop[m_owner]) begin
          m_ptr = (m_owner + 1) % N; m_owner = -1;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          e_err = 1; m_ptr = (m_owner + 1) % N; m_owner = -1; m_idle = 0;
        end
      end
    end
    e_gnt = '0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
  endtask

  logic [N-1:0] last_acc = '0;

  // One clock: inputs already driven at the negedge.
  task automatic cyc();
    logic [N-1:0] er;
    #1;
    er = model_rdy();
    check("in_rdy", in_rdy, er);
    last_acc = vld & er;
    @(posedge clk);
    model_edge();
    #1;
    check("gnt", gnt, e_gnt);
    check("flags", {out_vld, out_sop, out_eop, err}, {e_vld, e_sop, e_eop, e_err});
    if (e_vld) check("data", out_data, e_data);
    @(negedge clk);
  endtask

  // Random packet sources; pos is the beat index, -1 outside a packet.
  int         pos   [N];
  int         plen  [N];
  int         stall [N];
  bit         pend  [N];
  bit         psop  [N];
  bit         peop  [N];
  logic [7:0] pdata [N];

  task automatic present(input int p);
    pend[p]  = 1;
    psop[p]  = (pos[p] == 0) || ($urandom_range(0, 99) < 3);
    peop[p]  = (pos[p] == plen[p] - 1);
    pdata[p] = 8'($urandom_range(0, 255));
  endtask

  task automatic gen_drive();
    int r;
    for (int p = 0; p < N; p++) begin
      if (pend[p] && last_acc[p]) begin
        pend[p] = 0;
        if (pos[p] >= 0) begin
          pos[p]++;
          if (pos[p] == plen[p]) pos[p] = -1;
        end
      end
      if (!pend[p]) begin
        r = $urandom_range(0, 99);
        if (stall[p] > 0) begin
          stall[p]--;
        end else if (pos[p] < 0) begin
          if (r < 20) begin
            plen[p] = $urandom_range(1, 4);
            pos[p]  = 0;
            present(p);
          end else if (r < 23) begin
            pend[p]  = 1;
            psop[p]  = 0;
            peop[p]  = 1'($urandom_range(0, 1));
            pdata[p] = 8'($urandom_range(0, 255));
          end
        end else begin
          if (pos[p] > 0 && r < 2) stall[p] = TO - 2 + $urandom_range(0, 4);
          else if (r >= 25) present(p);
        end
      end
      vld[p] = pend[p];
      sop[p] = pend[p] & psop[p];
      eop[p] = pend[p] & peop[p];
      data[8*p +: 8] = pdata[p];
    end
  endtask

  initial begin
    for (int p = 0; p < N; p++) begin
      pos[p] = -1; plen[p] = 0; stall[p] = 0; pend[p] = 0; psop[p] = 0; peop[p] = 0;
      pdata[p] = 8'h00;
    end
    rst_n = 0; vld = '1; sop = '0; eop = '0; data = '0;
    @(negedge clk);
    repeat (3) cyc();
    check("rst_out", {gnt, out_vld, out_sop, out_eop, err, out_data}, 32'h0);
    rst_n = 1; vld = '0;
    cyc();

    // Three-beat packet on port 0.
    vld = 4'b0001; sop = 4'b0001; eop = 4'b0000; data = 32'h0000_00A1;
    cyc();
    check("p0_grant", gnt, 4'b0001);
    check("p0_lat1", out_vld, 1'b0);
    cyc();
    check("p0_b0", {out_vld, out_sop, out_eop, out_data}, {3'b110, 8'hA1});
    sop = 4'b0000; data = 32'h0000_00A2;
    cyc();
    check("p0_b1", {out_vld, out_sop, out_eop, out_data}, {3'b100, 8'hA2});
    eop = 4'b0001; data = 32'h0000_00A3;
    cyc();
    check("p0_b2", {out_vld, out_sop, out_eop, out_data}, {3'b101, 8'hA3});
    check("p0_rel", gnt, 4'b0000);
    vld = '0; sop = '0; eop = '0;
    cyc();
    check("p0_done", out_vld, 1'b0);

    // Single-beat packet on port 1 while port 2 waits.
    vld = 4'b0110; sop = 4'b0110; eop = 4'b0010; data = 32'h0077_5C00;
    cyc();
    check("p1_grant", gnt, 4'b0010);
    cyc();
    check("p1_beat", {out_vld, out_sop, out_eop, out_data}, {3'b111, 8'h5C});
    check("p1_rel", gnt, 4'b0000);
    vld = 4'b0100; sop = 4'b0100; eop = 4'b0100;
    cyc();
    check("p2_grant", gnt, 4'b0100);
    check("gap", out_vld, 1'b0);
    cyc();
    check("p2_beat", {out_vld, out_sop, out_eop, out_data}, {3'b111, 8'h77});
    vld = '0; sop = '0; eop = '0;
    cyc();

    // Randomized traffic with stalls, strays, mid-packet sops and resets.
    last_acc = '0;
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      gen_drive();
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
